// File: rtl/mux2_arbiter_if.sv
// Bundle of the two requester ports and the shared-bus outputs of the round-robin arbiter.
// The requesters (master) drive requests and payloads. The arbiter (slave) returns grants and the muxed bus.
interface mux2_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req_a;
    logic             req_b;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             bus_done;
    logic             gnt_a;
    logic             gnt_b;
    logic             choose;
    logic             bus_valid;
    logic [WIDTH-1:0] bus_data;

    modport master (
        output req_a, req_b, data_a, data_b, bus_done,
        input  gnt_a, gnt_b, choose, bus_valid, bus_data
    );

    modport slave (
        input  req_a, req_b, data_a, data_b, bus_done,
        output gnt_a, gnt_b, choose, bus_valid, bus_data
    );
endinterface

// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving the select of a shared 2:1 data mux.
// Each grant lasts one transaction and is bounded by MAX_HOLD cycles.
//
//   state | meaning
//   IDLE  | no owner, bus_done ignored, choose=0
//   OWN_A | requester A holds the bus (gnt_a=1, choose=0)
//   OWN_B | requester B holds the bus (gnt_b=1, choose=1)

module mux2 #(
    parameter int WIDTH = 32
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? b : a;
endmodule

module mux2_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst,
    mux2_arbiter_if.slave   bus
);
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          last_b_q, last_b_d;
    logic          gnt_a_q, gnt_b_q, choose_q;
    logic          own_req, other_req, drop, hold_hit;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        last_b_d  = last_b_q;
        own_req   = (state_q == OWN_B) ? bus.req_b : bus.req_a;
        other_req = (state_q == OWN_B) ? bus.req_a : bus.req_b;
        drop      = !own_req || bus.bus_done;
        hold_hit  = (hold_q == HOLD_LAST);

        case (state_q)
            IDLE: begin
                hold_d = '0;
                // On a tie the side that did not own the bus last wins.
                if (bus.req_a && (!bus.req_b || last_b_q)) begin
                    state_d = OWN_A;
                end else if (bus.req_b) begin
                    state_d = OWN_B;
                end
            end
            OWN_A, OWN_B: begin
                if (drop || hold_hit) begin
                    last_b_d = (state_q == OWN_B);
                    hold_d   = '0;
                    if (other_req) begin
                        state_d = (state_q == OWN_A) ? OWN_B : OWN_A;
                    end else if (drop) begin
                        state_d = IDLE;
                    end
                    // A hold expiry with no contender re-grants the same owner.
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            last_b_q <= 1'b1;
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            choose_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            last_b_q <= last_b_d;
            gnt_a_q  <= (state_d == OWN_A);
            gnt_b_q  <= (state_d == OWN_B);
            choose_q <= (state_d == OWN_B);
        end
    end

    assign bus.gnt_a     = gnt_a_q;
    assign bus.gnt_b     = gnt_b_q;
    assign bus.choose    = choose_q;
    assign bus.bus_valid = (gnt_a_q & bus.req_a) | (gnt_b_q & bus.req_b);

    mux2 #(.WIDTH(WIDTH)) u_mux (
        .sel (choose_q),
        .a   (bus.data_a),
        .b   (bus.data_b),
        .y   (bus.bus_data)
    );
endmodule

// File: tb/tb_mux2_arbiter.sv
// Self-checking bench for mux2_arbiter. It runs a vector table, directed corner sequences,
// and a randomized run compared against an ownership model.
module tb_mux2_arbiter;
    localparam int WIDTH    = 32;
    localparam int MAX_HOLD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    mux2_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux2_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ra, rb, done;
        logic [31:0] da, db;
        logic        ga, gb, ch, val;
        logic [31:0] bd;
    } vec_t;

    vec_t tbl [10];

    // Ownership model: owner 0=none 1=A 2=B, held = grant cycles in the current ownership.
    int m_owner, m_held;
    bit m_last_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_a = 0; bus.req_b = 0; bus.bus_done = 0;
        bus.data_a = '0; bus.data_b = '0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        m_owner = 0; m_held = 0; m_last_b = 1;
    endtask

    task automatic model_step(input bit ra, input bit rb, input bit done);
        bit mine, other;
        if (m_owner == 0) begin
            if (ra && rb)  m_owner = m_last_b ? 1 : 2;
            else if (ra)   m_owner = 1;
            else if (rb)   m_owner = 2;
            m_held = 1;
        end else begin
            mine  = (m_owner == 1) ? ra : rb;
            other = (m_owner == 1) ? rb : ra;
            if (!mine || done || m_held == MAX_HOLD) begin
                m_last_b = (m_owner == 2);
                if (other)              m_owner = 3 - m_owner;
                else if (!mine || done) m_owner = 0;
                m_held = 1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic model_compare(input int cyc);
        logic        e_ga, e_gb, e_val;
        logic [31:0] e_bd;
        e_ga  = (m_owner == 1);
        e_gb  = (m_owner == 2);
        e_val = (e_ga && bus.req_a) || (e_gb && bus.req_b);
        e_bd  = e_gb ? bus.data_b : bus.data_a;
        check($sformatf("rnd%0d.gnt", cyc), {bus.gnt_a, bus.gnt_b, bus.choose}, {e_ga, e_gb, e_gb});
        check($sformatf("rnd%0d.valid", cyc), bus.bus_valid, e_val);
        check($sformatf("rnd%0d.data", cyc), bus.bus_data, e_bd);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'hA0000000, 32'hB0000000, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA0000000};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'hA0000001, 32'hB0000001, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA0000001};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'hA0000002, 32'hB0000002, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA0000002};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'hA0000003, 32'hB0000003, 1'b0, 1'b1, 1'b1, 1'b1, 32'hB0000003};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 32'hA0000004, 32'hB0000004, 1'b0, 1'b1, 1'b1, 1'b0, 32'hB0000004};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 32'hA0000005, 32'hB0000005, 1'b1, 1'b0, 1'b0, 1'b0, 32'hA0000005};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 32'hA0000006, 32'hB0000006, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA0000006};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 32'hA0000007, 32'hB0000007, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA0000007};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 32'hA0000008, 32'hB0000008, 1'b0, 1'b1, 1'b1, 1'b1, 32'hB0000008};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 32'hA0000009, 32'hB0000009, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA0000009};

        do_reset();
        check("reset.gnt", {bus.gnt_a, bus.gnt_b, bus.choose, bus.bus_valid}, 4'b0000);

        // Vector table: outputs are checked before the edge that consumes each row.
        for (int i = 0; i < 10; i++) begin
            bus.req_a = tbl[i].ra; bus.req_b = tbl[i].rb; bus.bus_done = tbl[i].done;
            bus.data_a = tbl[i].da; bus.data_b = tbl[i].db;
            #1;
            check($sformatf("vec%0d.gnt_a", i), bus.gnt_a, tbl[i].ga);
            check($sformatf("vec%0d.gnt_b", i), bus.gnt_b, tbl[i].gb);
            check($sformatf("vec%0d.choose", i), bus.choose, tbl[i].ch);
            check($sformatf("vec%0d.valid", i), bus.bus_valid, tbl[i].val);
            check($sformatf("vec%0d.data", i), bus.bus_data, tbl[i].bd);
            tick();
        end

        // Asynchronous reset in the middle of a grant.
        do_reset();
        bus.req_a = 1;
        tick();
        check("async.pre_gnt_a", bus.gnt_a, 1'b1);
        #2 rst = 1;
        #1;
        check("async.outs", {bus.gnt_a, bus.gnt_b, bus.choose, bus.bus_valid}, 4'b0000);
        #1 rst = 0;

        // Single A transaction ended by bus_done.
        do_reset();
        bus.req_a = 1; bus.data_a = 32'hDEADBEEF; bus.data_b = 32'h0BADF00D;
        tick();
        check("single.gnt_a", {bus.gnt_a, bus.choose, bus.bus_valid}, 3'b101);
        check("single.data", bus.bus_data, 32'hDEADBEEF);
        tick(); tick(); tick();
        check("single.hold", bus.gnt_a, 1'b1);
        bus.bus_done = 1;
        tick();
        bus.bus_done = 0;
        check("single.release", {bus.gnt_a, bus.gnt_b}, 2'b00);
        bus.req_a = 0;

        // Tie after reset: A first, then B with no idle bubble.
        do_reset();
        bus.req_a = 1; bus.req_b = 1; bus.data_b = 32'h12345678; bus.data_a = 32'h55555555;
        tick();
        check("tie.first", {bus.gnt_a, bus.gnt_b}, 2'b10);
        bus.bus_done = 1;
        tick();
        bus.bus_done = 0;
        check("tie.second", {bus.gnt_a, bus.gnt_b, bus.choose}, 3'b011);
        check("tie.data", bus.bus_data, 32'h12345678);

        // Hold limit: A loses the bus after MAX_HOLD grant cycles to a waiting B.
        do_reset();
        bus.req_a = 1;
        tick();
        for (int c = 1; c <= MAX_HOLD; c++) begin
            check($sformatf("hold.c%0d", c), {bus.gnt_a, bus.gnt_b}, 2'b10);
            if (c == 2) bus.req_b = 1;
            tick();
        end
        check("hold.handover", {bus.gnt_a, bus.gnt_b, bus.choose}, 3'b011);

        // Solo hold expiry keeps A granted continuously.
        do_reset();
        bus.req_a = 1;
        tick();
        for (int c = 1; c <= 40; c++) begin
            check($sformatf("solo.c%0d", c), {bus.gnt_a, bus.gnt_b}, 2'b10);
            tick();
        end
        bus.req_a = 0;

        // req drop and bus_done together cause one release to IDLE.
        do_reset();
        bus.req_a = 1;
        tick(); tick();
        bus.req_a = 0; bus.bus_done = 1;
        #1;
        check("simul.valid_drop", {bus.gnt_a, bus.bus_valid}, 2'b10);
        tick();
        bus.bus_done = 0;
        check("simul.idle", {bus.gnt_a, bus.gnt_b}, 2'b00);
        tick();
        check("simul.stays_idle", {bus.gnt_a, bus.gnt_b}, 2'b00);

        // Randomized run against the ownership model.
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            if ($urandom_range(0, 7) == 0) bus.req_a = ~bus.req_a;
            if ($urandom_range(0, 7) == 0) bus.req_b = ~bus.req_b;
            bus.bus_done = ($urandom_range(0, 9) == 0);
            bus.data_a = $urandom;
            bus.data_b = $urandom;
            #1;
            model_compare(cyc);
            check($sformatf("rnd%0d.excl", cyc), bus.gnt_a & bus.gnt_b, 1'b0);
            @(posedge clk);
            model_step(bus.req_a, bus.req_b, bus.bus_done);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
